// File: rtl/imem_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl_pkg
// Shared definitions for the instruction-memory load controller:
//   DEF_WORD_LEN   - default instruction / address width
//   DEF_MEM_SIZE   - default instruction memory depth in bytes (power of two)
//   MEM_CELL_SIZE  - width of one memory cell (byte)
//   NOP_INSTR      - instruction word presented to IF/ID while fetch is stalled
//   ctrl_state_e   - controller state encoding
// -----------------------------------------------------------------------------
package imem_load_ctrl_pkg;

    localparam int unsigned DEF_WORD_LEN  = 32;
    localparam int unsigned DEF_MEM_SIZE  = 1024;
    localparam int unsigned MEM_CELL_SIZE = 8;

    localparam logic [DEF_WORD_LEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/imem_load_ctrl_write_port.sv
// -----------------------------------------------------------------------------
// imem_write_port
// Registered byte-write stage toward the instruction memory. A byte accepted
// in cycle t appears on the memory write port in cycle t+1. Bytes whose index
// lies at or beyond the memory depth are consumed upstream but never written.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset; cancels any pending write
//   wr_fire_i    a byte was accepted this cycle
//   wr_idx_i     index of the accepted byte (AW+1 bits, may exceed depth)
//   wr_data_i    accepted byte
//   mem_we_o     memory byte write enable
//   mem_waddr_o  memory byte write address
//   mem_wdata_o  memory byte write data
// -----------------------------------------------------------------------------
module imem_write_port
    import imem_load_ctrl_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_fire_i,
    input  logic [AW:0]              wr_idx_i,
    input  logic [MEM_CELL_SIZE-1:0] wr_data_i,
    output logic                     mem_we_o,
    output logic [AW-1:0]            mem_waddr_o,
    output logic [MEM_CELL_SIZE-1:0] mem_wdata_o
);

    logic                     we_q;
    logic [AW-1:0]            waddr_q;
    logic [MEM_CELL_SIZE-1:0] wdata_q;
    logic                     in_range;

    // Depth is 2**AW, so an index at or past the end has its top bit set.
    // Checking that bit (instead of truncating) keeps overflow bytes from
    // wrapping back onto low addresses.
    assign in_range = ~wr_idx_i[AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= wr_fire_i & in_range;
            if (wr_fire_i && in_range) begin
                waddr_q <= wr_idx_i[AW-1:0];
                wdata_q <= wr_data_i;
            end
        end
    end

    assign mem_we_o    = we_q;
    assign mem_waddr_o = waddr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
// Owns the write side of the byte-addressed instruction memory and gates its
// read side toward the fetch stage. After reset (and on any later reload
// request from RUN) it accepts a program as a valid/ready byte stream, writes
// one byte per cycle, stalls fetch with a NOP meanwhile, then releases the
// pipeline with a one-cycle flush and PC-restart pulse.
//
// Ports:
//   clk, rst      clock (rising edge) / synchronous active-high reset
//   load_start    request a (re)load; honoured in BOOT and RUN only
//   load_len      number of bytes to load, sampled with load_start
//   byte_in       program byte, byte_valid / byte_ready handshake
//   mem_we, mem_waddr, mem_wdata   registered memory byte-write port
//   fetch_addr    PC from IF; mem_raddr is its low AW bits
//   mem_rdata     assembled big-endian word from memory
//   fetch_instr   instruction to IF/ID (NOP while stalled)
//   fetch_stall   freeze PC and IF/ID
//   pipe_flush    one-cycle flush of the pipeline registers
//   pc_restart    one-cycle request to load PC with 0
//   load_busy     high in LOAD and DRAIN
//   load_err      sticky: requested length exceeded memory depth
// -----------------------------------------------------------------------------
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int unsigned WORD_LEN = DEF_WORD_LEN,
    parameter int unsigned MEM_SIZE = DEF_MEM_SIZE,
    parameter int unsigned AW       = $clog2(MEM_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [AW:0]              load_len,
    input  logic [MEM_CELL_SIZE-1:0] byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_waddr,
    output logic [MEM_CELL_SIZE-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0]      fetch_addr,
    output logic [AW-1:0]            mem_raddr,
    input  logic [WORD_LEN-1:0]      mem_rdata,
    output logic [WORD_LEN-1:0]      fetch_instr,
    output logic                     fetch_stall,
    output logic                     pipe_flush,
    output logic                     pc_restart,
    output logic                     load_busy,
    output logic                     load_err
);

    localparam logic [AW:0] MEM_SIZE_W = (AW+1)'(MEM_SIZE);
    localparam logic [AW:0] LEN_ONE    = (AW+1)'(1);

    ctrl_state_e state_q;
    logic [AW:0] cnt_q;
    logic [AW:0] len_q;
    logic [AW:0] cnt_d;
    logic        byte_ready_q;
    logic        fetch_stall_q;
    logic        pipe_flush_q;
    logic        pc_restart_q;
    logic        load_busy_q;
    logic        load_err_q;
    logic        fire;
    logic        unused_fetch_hi;

    // byte_ready_q is only ever set while in LOAD, so no state qualifier here.
    assign fire  = byte_valid & byte_ready_q;
    assign cnt_d = cnt_q + LEN_ONE;

    // Single-process FSM. byte_ready and fetch_stall are kept as registers
    // that change on the same edges the state does, which reproduces
    // "cnt < len in LOAD" and "stall unless RUN" without decoding the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            cnt_q         <= '0;
            len_q         <= '0;
            byte_ready_q  <= 1'b0;
            fetch_stall_q <= 1'b1;
            pipe_flush_q  <= 1'b0;
            pc_restart_q  <= 1'b0;
            load_busy_q   <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            pipe_flush_q <= 1'b0;
            pc_restart_q <= 1'b0;
            unique case (state_q)
                ST_BOOT, ST_RUN: begin
                    if (load_start) begin
                        len_q         <= load_len;
                        cnt_q         <= '0;
                        load_err_q    <= (load_len > MEM_SIZE_W);
                        load_busy_q   <= 1'b1;
                        fetch_stall_q <= 1'b1;
                        if (load_len == '0) begin
                            byte_ready_q <= 1'b0;
                            state_q      <= ST_DRAIN;
                        end else begin
                            byte_ready_q <= 1'b1;
                            state_q      <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (fire) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) begin
                            byte_ready_q <= 1'b0;
                            state_q      <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    load_busy_q  <= 1'b0;
                    pipe_flush_q <= 1'b1;
                    pc_restart_q <= 1'b1;
                    state_q      <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    fetch_stall_q <= 1'b0;
                    state_q       <= ST_RUN;
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    imem_write_port #(
        .AW (AW)
    ) u_write_port (
        .clk         (clk),
        .rst         (rst),
        .wr_fire_i   (fire),
        .wr_idx_i    (cnt_q),
        .wr_data_i   (byte_in),
        .mem_we_o    (mem_we),
        .mem_waddr_o (mem_waddr),
        .mem_wdata_o (mem_wdata)
    );

    assign mem_raddr       = fetch_addr[AW-1:0];
    assign unused_fetch_hi = ^fetch_addr[WORD_LEN-1:AW];

    always_comb begin
        fetch_instr = mem_rdata;
        if (fetch_stall_q) begin
            fetch_instr = WORD_LEN'(NOP_INSTR);
        end
    end

    assign byte_ready  = byte_ready_q;
    assign fetch_stall = fetch_stall_q;
    assign pipe_flush  = pipe_flush_q;
    assign pc_restart  = pc_restart_q;
    assign load_busy   = load_busy_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_load_ctrl
// Directed self-checking bench for imem_load_ctrl with a byte-wide memory
// model assembling big-endian words for the fetch side.
// -----------------------------------------------------------------------------
module tb_imem_load_ctrl;

    localparam int unsigned WL  = 32;
    localparam int unsigned MSZ = 1024;
    localparam int unsigned AW  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW:0]   load_len;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [WL-1:0] fetch_addr;
    logic [AW-1:0] mem_raddr;
    logic [WL-1:0] mem_rdata;
    logic [WL-1:0] fetch_instr;
    logic          fetch_stall;
    logic          pipe_flush;
    logic          pc_restart;
    logic          load_busy;
    logic          load_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    tb_mem [0:MSZ-1];
    logic [AW-1:0] ra1, ra2, ra3;

    always #5 clk = ~clk;

    imem_load_ctrl #(
        .WORD_LEN (WL),
        .MEM_SIZE (MSZ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_len    (load_len),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .fetch_addr  (fetch_addr),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .fetch_instr (fetch_instr),
        .fetch_stall (fetch_stall),
        .pipe_flush  (pipe_flush),
        .pc_restart  (pc_restart),
        .load_busy   (load_busy),
        .load_err    (load_err)
    );

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_waddr] <= mem_wdata;
    end

    assign ra1 = mem_raddr + 10'd1;
    assign ra2 = mem_raddr + 10'd2;
    assign ra3 = mem_raddr + 10'd3;
    assign mem_rdata = {tb_mem[mem_raddr], tb_mem[ra1], tb_mem[ra2], tb_mem[ra3]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full 8-byte load with byte_valid held high; starts in BOOT or RUN,
    // ends in RUN.
    task automatic full_load8(input logic [63:0] p);
        load_start = 1'b1;
        load_len   = 11'd8;
        step();
        load_start = 1'b0;
        chk("ld_busy", 32'(load_busy), 32'd1);
        chk("ld_stall", 32'(fetch_stall), 32'd1);
        chk("ld_nop", fetch_instr, 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("ld_ready", 32'(byte_ready), 32'd1);
            byte_valid = 1'b1;
            byte_in    = p[63-8*i -: 8];
            step();
            chk("ld_we", 32'(mem_we), 32'd1);
            chk("ld_waddr", 32'(mem_waddr), 32'(i));
            chk("ld_wdata", 32'(mem_wdata), 32'(p[63-8*i -: 8]));
        end
        byte_valid = 1'b0;
        chk("drain_ready", 32'(byte_ready), 32'd0);
        chk("drain_busy", 32'(load_busy), 32'd1);
        chk("drain_flush", 32'(pipe_flush), 32'd0);
        step();
        chk("rel_flush", 32'(pipe_flush), 32'd1);
        chk("rel_restart", 32'(pc_restart), 32'd1);
        chk("rel_stall", 32'(fetch_stall), 32'd1);
        chk("rel_we", 32'(mem_we), 32'd0);
        chk("rel_busy", 32'(load_busy), 32'd0);
        step();
        chk("run_flush", 32'(pipe_flush), 32'd0);
        chk("run_restart", 32'(pc_restart), 32'd0);
        chk("run_stall", 32'(fetch_stall), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int nwe;
        int addr_bad;

        rst        = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        fetch_addr = '0;

        // Reset state
        step();
        step();
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_waddr", 32'(mem_waddr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_flush", 32'(pipe_flush), 32'd0);
        chk("rst_restart", 32'(pc_restart), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_busy", 32'(load_busy), 32'd0);
        chk("rst_stall", 32'(fetch_stall), 32'd1);
        chk("rst_nop", fetch_instr, 32'h0);
        rst = 1'b0;
        step();
        chk("boot_stall", 32'(fetch_stall), 32'd1);

        // Basic 8-byte load, valid always high
        full_load8(64'h8020000A_04400800);
        fetch_addr = 32'h0;
        #1;
        chk("t1_word0", fetch_instr, 32'h8020000A);
        fetch_addr = 32'h4;
        #1;
        chk("t1_word4", fetch_instr, 32'h04400800);
        fetch_addr = 32'h0000_0400;
        #1;
        chk("t1_raddr_wrap", 32'(mem_raddr), 32'h0);
        chk("t1_word_hi", fetch_instr, 32'h8020000A);

        // Toggled byte_valid: 8 bytes over 16 handshake cycles
        load_start = 1'b1;
        load_len   = 11'd8;
        step();
        load_start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            logic [63:0] p2;
            p2 = 64'h11223344_55667788;
            chk("tg_ready", 32'(byte_ready), (c < 15) ? 32'd1 : 32'd0);
            byte_valid = (c % 2 == 0);
            byte_in    = (c % 2 == 0) ? p2[63-8*(c/2) -: 8] : 8'hFF;
            step();
            chk("tg_we", 32'(mem_we), (c % 2 == 0) ? 32'd1 : 32'd0);
            if (c % 2 == 0) begin
                chk("tg_waddr", 32'(mem_waddr), 32'(c/2));
                chk("tg_wdata", 32'(mem_wdata), 32'(p2[63-8*(c/2) -: 8]));
            end
        end
        byte_valid = 1'b0;
        chk("tg_flush", 32'(pipe_flush), 32'd1);
        step();
        chk("tg_stall", 32'(fetch_stall), 32'd0);
        fetch_addr = 32'h0;
        #1;
        chk("tg_word0", fetch_instr, 32'h11223344);
        fetch_addr = 32'h4;
        #1;
        chk("tg_word4", fetch_instr, 32'h55667788);

        // Zero-length load
        fetch_addr = 32'h0;
        load_start = 1'b1;
        load_len   = 11'd0;
        #1;
        chk("z_pass", fetch_instr, 32'h11223344);
        chk("z_pass_stall", 32'(fetch_stall), 32'd0);
        step();
        load_start = 1'b0;
        chk("z_ready", 32'(byte_ready), 32'd0);
        chk("z_we", 32'(mem_we), 32'd0);
        chk("z_flush0", 32'(pipe_flush), 32'd0);
        chk("z_stall", 32'(fetch_stall), 32'd1);
        chk("z_nop", fetch_instr, 32'h0);
        chk("z_busy", 32'(load_busy), 32'd1);
        step();
        chk("z_flush", 32'(pipe_flush), 32'd1);
        chk("z_restart", 32'(pc_restart), 32'd1);
        chk("z_we2", 32'(mem_we), 32'd0);
        chk("z_ready2", 32'(byte_ready), 32'd0);
        step();
        chk("z_run_stall", 32'(fetch_stall), 32'd0);
        chk("z_run_flush", 32'(pipe_flush), 32'd0);

        // Overflow: MEM_SIZE+2 bytes
        load_start = 1'b1;
        load_len   = 11'(MSZ + 2);
        step();
        load_start = 1'b0;
        chk("ov_err", 32'(load_err), 32'd1);
        nwe      = 0;
        addr_bad = 0;
        for (int i = 0; i < MSZ + 2; i++) begin
            byte_valid = 1'b1;
            byte_in    = (i < MSZ) ? (8'(i) ^ 8'h5A) : 8'hEE;
            step();
            if (mem_we) begin
                nwe++;
                if (32'(mem_waddr) != 32'(i)) addr_bad++;
            end
            if (i >= MSZ) chk("ov_drop", 32'(mem_we), 32'd0);
        end
        byte_valid = 1'b0;
        chk("ov_we_count", 32'(nwe), 32'(MSZ));
        chk("ov_addr_seq", 32'(addr_bad), 32'd0);
        chk("ov_ready", 32'(byte_ready), 32'd0);
        step();
        chk("ov_flush", 32'(pipe_flush), 32'd1);
        step();
        chk("ov_err_sticky", 32'(load_err), 32'd1);
        fetch_addr = 32'h0;
        #1;
        chk("ov_word0", fetch_instr, 32'h5A5B5859);
        fetch_addr = 32'd1020;
        #1;
        chk("ov_word1020", fetch_instr, 32'hA6A7A4A5);

        // Reset after 3 of 8 bytes
        fetch_addr = 32'h0;
        load_start = 1'b1;
        load_len   = 11'd8;
        step();
        load_start = 1'b0;
        chk("r_err_clr", 32'(load_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1;
            byte_in    = 8'hAA + 8'(i);
            step();
        end
        chk("r_we_pre", 32'(mem_we), 32'd1);
        rst = 1'b1;
        step();
        chk("r_we", 32'(mem_we), 32'd0);
        chk("r_busy", 32'(load_busy), 32'd0);
        chk("r_stall", 32'(fetch_stall), 32'd1);
        chk("r_nop", fetch_instr, 32'h0);
        chk("r_ready", 32'(byte_ready), 32'd0);
        chk("r_flush", 32'(pipe_flush), 32'd0);
        rst        = 1'b0;
        byte_valid = 1'b0;
        step();
        chk("r_boot_stall", 32'(fetch_stall), 32'd1);
        chk("r_boot_ready", 32'(byte_ready), 32'd0);
        full_load8(64'h01020304_05060708);
        fetch_addr = 32'h0;
        #1;
        chk("r_word0", fetch_instr, 32'h01020304);

        // Reload from RUN, second load_start during LOAD ignored
        fetch_addr = 32'h4;
        load_start = 1'b1;
        load_len   = 11'd4;
        #1;
        chk("rl_pass", fetch_instr, 32'h05060708);
        chk("rl_pass_stall", 32'(fetch_stall), 32'd0);
        step();
        chk("rl_stall", 32'(fetch_stall), 32'd1);
        chk("rl_nop", fetch_instr, 32'h0);
        chk("rl_busy", 32'(load_busy), 32'd1);
        load_start = 1'b1;
        load_len   = 11'd8;
        for (int i = 0; i < 4; i++) begin
            chk("rl_ready", 32'(byte_ready), 32'd1);
            byte_valid = 1'b1;
            byte_in    = 8'hD0 + 8'(i);
            step();
            load_start = 1'b0;
            chk("rl_we", 32'(mem_we), 32'd1);
            chk("rl_waddr", 32'(mem_waddr), 32'(i));
        end
        byte_valid = 1'b0;
        chk("rl_len_kept", 32'(byte_ready), 32'd0);
        chk("rl_drain_busy", 32'(load_busy), 32'd1);
        step();
        chk("rl_flush", 32'(pipe_flush), 32'd1);
        step();
        chk("rl_run_stall", 32'(fetch_stall), 32'd0);
        fetch_addr = 32'h0;
        #1;
        chk("rl_word0", fetch_instr, 32'hD0D1D2D3);
        fetch_addr = 32'h4;
        #1;
        chk("rl_word4", fetch_instr, 32'h05060708);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
